// File: rtl/mux_pkg.sv
// Shared types for the stream multiplexer family.
package mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mux_mode_e;

endpackage

// File: rtl/mux_stream_n_rr_pick.sv
// Rotating-priority picker: first asserted request at or after ptr, wrapping at N.
module rr_pick #(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    logic [SELW:0] cand_s;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand_s    = '0;
        for (int j = N - 1; j >= 0; j--) begin
            cand_s = {1'b0, ptr} + (SELW + 1)'(j);
            if (cand_s >= (SELW + 1)'(N)) begin
                cand_s = cand_s - (SELW + 1)'(N);
            end else begin
                cand_s = cand_s;
            end
            if (req[cand_s[SELW-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand_s[SELW-1:0];
            end else begin
                gnt_valid = gnt_valid;
            end
        end
    end

endmodule

// File: rtl/mux_stream_n.sv
// N-channel handshaked stream mux with a one-deep output register,
// steered by an external select or by a round-robin pointer.
module mux_stream_n
    import mux_pkg::*;
#(
    parameter int        N     = 4,
    parameter int        WIDTH = 4,
    parameter mux_mode_e MODE  = MODE_SEL,
    localparam int       SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    s,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel
);

    logic               valid_r;
    logic [WIDTH-1:0]   data_r;
    logic [SELW-1:0]    sel_r;
    logic [SELW-1:0]    ptr_r;

    logic               can_load_s;
    logic               rr_gv_s;
    logic [SELW-1:0]    rr_gi_s;
    logic               gnt_valid_s;
    logic [SELW-1:0]    gnt_idx_s;
    logic               xfer_s;
    logic [WIDTH-1:0]   gnt_data_s;
    logic [SELW-1:0]    ptr_next_s;

    assign can_load_s = ~valid_r | out_ready;

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req       (in_valid),
        .ptr       (ptr_r),
        .gnt_valid (rr_gv_s),
        .gnt_idx   (rr_gi_s)
    );

    // Grant source by mode; a select outside 0..N-1 grants nobody.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_idx_s   = '0;
        if (MODE == MODE_RR) begin
            gnt_valid_s = rr_gv_s;
            gnt_idx_s   = rr_gi_s;
        end else begin
            gnt_valid_s = ({1'b0, s} < (SELW + 1)'(N));
            gnt_idx_s   = s;
        end
    end

    // Ready goes only to the granted channel; data never feeds this path.
    always_comb begin
        in_ready = '0;
        if (gnt_valid_s && can_load_s) begin
            in_ready[gnt_idx_s] = 1'b1;
        end else begin
            in_ready = '0;
        end
    end

    // Data mux, transfer detect and pointer wrap at N.
    always_comb begin
        gnt_data_s = '0;
        xfer_s     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (SELW'(i) == gnt_idx_s) begin
                gnt_data_s = in_data[i*WIDTH +: WIDTH];
                xfer_s     = gnt_valid_s & can_load_s & in_valid[i];
            end else begin
                gnt_data_s = gnt_data_s;
            end
        end
        if (gnt_idx_s == SELW'(N - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = gnt_idx_s + SELW'(1);
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            data_r  <= '0;
            sel_r   <= '0;
            ptr_r   <= '0;
        end else if (xfer_s) begin
            valid_r <= 1'b1;
            data_r  <= gnt_data_s;
            sel_r   <= gnt_idx_s;
            if (MODE == MODE_RR) begin
                ptr_r <= ptr_next_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end else if (out_ready && valid_r) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign out_sel   = sel_r;

endmodule

// File: tb/tb_mux_stream_n.sv
// Four configurations (4x4 select, 4x4 RR, 5x8 RR, 5x8 select) driven in lockstep
// and compared every cycle against a queue-free behavioural model.
module tb_mux_stream_n;
    import mux_pkg::*;

    localparam int CFG_N [4] = '{4, 4, 5, 5};
    localparam int CFG_W [4] = '{4, 4, 8, 8};
    localparam bit CFG_RR[4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  vld;
    logic [7:0]  dat [5];
    logic [2:0]  s;
    logic        ordy;
    logic [15:0] data4;
    logic [39:0] data8;

    logic        va, vb, vc, vd;
    logic [3:0]  da, db;
    logic [7:0]  dc, dd;
    logic [1:0]  sa, sb;
    logic [2:0]  sc, sd;
    logic [3:0]  ra, rb;
    logic [4:0]  rc, rd;

    logic        o_v [4];
    logic [7:0]  o_d [4];
    logic [2:0]  o_s [4];
    logic [4:0]  o_r [4];

    bit          m_v [4];
    logic [7:0]  m_d [4];
    int          m_s [4];
    int          m_p [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < 4; g++) begin : g_d4
        assign data4[g*4 +: 4] = dat[g][3:0];
    end
    for (g = 0; g < 5; g++) begin : g_d8
        assign data8[g*8 +: 8] = dat[g];
    end

    mux_stream_n #(.N(4), .WIDTH(4), .MODE(MODE_SEL)) u_sel4 (
        .clk(clk), .reset(reset), .in_valid(vld[3:0]), .in_ready(ra), .in_data(data4),
        .s(s[1:0]), .out_valid(va), .out_ready(ordy), .out_data(da), .out_sel(sa));
    mux_stream_n #(.N(4), .WIDTH(4), .MODE(MODE_RR)) u_rr4 (
        .clk(clk), .reset(reset), .in_valid(vld[3:0]), .in_ready(rb), .in_data(data4),
        .s(s[1:0]), .out_valid(vb), .out_ready(ordy), .out_data(db), .out_sel(sb));
    mux_stream_n #(.N(5), .WIDTH(8), .MODE(MODE_RR)) u_rr5 (
        .clk(clk), .reset(reset), .in_valid(vld), .in_ready(rc), .in_data(data8),
        .s(s), .out_valid(vc), .out_ready(ordy), .out_data(dc), .out_sel(sc));
    mux_stream_n #(.N(5), .WIDTH(8), .MODE(MODE_SEL)) u_sel5 (
        .clk(clk), .reset(reset), .in_valid(vld), .in_ready(rd), .in_data(data8),
        .s(s), .out_valid(vd), .out_ready(ordy), .out_data(dd), .out_sel(sd));

    assign o_v[0] = va;            assign o_v[1] = vb;
    assign o_v[2] = vc;            assign o_v[3] = vd;
    assign o_d[0] = {4'd0, da};    assign o_d[1] = {4'd0, db};
    assign o_d[2] = dc;            assign o_d[3] = dd;
    assign o_s[0] = {1'b0, sa};    assign o_s[1] = {1'b0, sb};
    assign o_s[2] = sc;            assign o_s[3] = sd;
    assign o_r[0] = {1'b0, ra};    assign o_r[1] = {1'b0, rb};
    assign o_r[2] = rc;            assign o_r[3] = rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: decide the grant from the rules, check in_ready, advance the state.
    task automatic model_step(input int k);
        int         n;
        int         sel;
        int         gi;
        bit         gv;
        bit         can_load;
        logic [7:0] mask;
        logic [4:0] exp_rdy;
        n        = CFG_N[k];
        sel      = (n == 4) ? int'(s[1:0]) : int'(s);
        mask     = (CFG_W[k] == 4) ? 8'h0F : 8'hFF;
        can_load = !m_v[k] || ordy;
        gv = 1'b0;
        gi = 0;
        if (!CFG_RR[k]) begin
            if (sel < n) begin
                gv = 1'b1;
                gi = sel;
            end
        end else begin
            for (int j = 0; j < n; j++) begin
                int c;
                c = (m_p[k] + j) % n;
                if (!gv && vld[c]) begin
                    gv = 1'b1;
                    gi = c;
                end
            end
        end
        exp_rdy = 5'd0;
        if (gv && can_load) exp_rdy[gi] = 1'b1;
        chk($sformatf("in_ready[%0d]", k), 64'(o_r[k]), 64'(exp_rdy));
        if (reset) begin
            m_v[k] = 1'b0;
            m_d[k] = 8'd0;
            m_s[k] = 0;
            m_p[k] = 0;
        end else if (gv && can_load && vld[gi]) begin
            m_v[k] = 1'b1;
            m_d[k] = dat[gi] & mask;
            m_s[k] = gi;
            if (CFG_RR[k]) m_p[k] = (gi + 1) % n;
        end else if (ordy && m_v[k]) begin
            m_v[k] = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic [4:0] v, input logic [2:0] sv,
                        input logic rdy, input bit new_data);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("out_valid[%0d]", k), 64'(o_v[k]), 64'(m_v[k]));
            chk($sformatf("out_data[%0d]", k), 64'(o_d[k]), 64'(m_d[k]));
            chk($sformatf("out_sel[%0d]", k), 64'(o_s[k]), 64'(m_s[k]));
        end
        reset = r;
        vld   = v;
        s     = sv;
        ordy  = rdy;
        if (new_data) begin
            for (int i = 0; i < 5; i++) dat[i] = 8'($urandom);
        end
        #1;
        for (int k = 0; k < 4; k++) model_step(k);
    endtask

    initial begin
        reset  = 1'b1;
        vld    = 5'd0;
        s      = 3'd0;
        ordy   = 1'b0;
        dat[0] = 8'h10;
        dat[1] = 8'h23;
        dat[2] = 8'h3C;
        dat[3] = 8'h4F;
        dat[4] = 8'h5A;
        for (int k = 0; k < 4; k++) begin
            m_v[k] = 1'b0;
            m_d[k] = 8'd0;
            m_s[k] = 0;
            m_p[k] = 0;
        end
        @(posedge clk);

        // Select stepping with everything valid; RR instances rotate meanwhile.
        for (int c = 0; c < 20; c++) step(1'b0, 5'b11111, 3'(c / 5), 1'b1, 1'b0);
        chk("sel4 last word", 64'(da), 64'h0F);

        // Backpressure while the select moves.
        step(1'b0, 5'b11111, 3'd2, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) step(1'b0, 5'b11111, 3'd3, 1'b0, 1'b0);
        step(1'b0, 5'b11111, 3'd3, 1'b1, 1'b0);
        step(1'b0, 5'b11111, 3'd3, 1'b1, 1'b0);

        // Sparse round-robin from a fresh pointer with toggling consumer.
        step(1'b1, 5'b01010, 3'd0, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) step(1'b0, 5'b01010, 3'd0, (c % 2) == 0, 1'b0);

        // Reset while stalled, then lowest valid channel wins.
        step(1'b0, 5'b11111, 3'd1, 1'b1, 1'b0);
        step(1'b0, 5'b11111, 3'd1, 1'b0, 1'b0);
        step(1'b0, 5'b11111, 3'd1, 1'b0, 1'b0);
        step(1'b1, 5'b11111, 3'd1, 1'b0, 1'b0);
        step(1'b0, 5'b01100, 3'd1, 1'b1, 1'b0);
        step(1'b0, 5'b01100, 3'd1, 1'b1, 1'b0);

        // Out-of-range select on the five-channel instance.
        for (int c = 0; c < 6; c++) step(1'b0, 5'b11111, 3'(5 + c % 3), 1'b1, 1'b0);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 49) == 0, 5'($urandom), 3'($urandom),
                 $urandom_range(0, 3) != 0, 1'b1);
        end
        step(1'b0, 5'b00000, 3'd0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
